// File: rtl/m_bpred.sv
// Direct-mapped BTB with saturating per-entry direction counters for the RV32 pipeline.
// IF looks up combinationally each cycle; Ex writes back resolved branches and receives a redirect flag.
module m_bpred #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_ce,
  input  logic [31:0]       w_if_pc,
  output logic              w_pred_taken,
  output logic [31:0]       w_pred_tpc,
  input  logic              w_upd_valid,
  input  logic              w_upd_is_br,
  input  logic [31:0]       w_upd_pc,
  input  logic              w_upd_taken,
  input  logic [31:0]       w_upd_tpc,
  input  logic              w_upd_pred_taken,
  input  logic [31:0]       w_upd_pred_tpc,
  output logic              w_upd_mispred,
  output logic [STAT_W-1:0] w_nbr,
  output logic [STAT_W-1:0] w_nmiss
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_WT   = CNT_W'(2 ** (CNT_W - 1));
  localparam logic [CNT_W-1:0]  CNT_WNT  = CNT_W'(2 ** (CNT_W - 1) - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic             valid_r [ENTRIES];
  logic [TAG_W-1:0] tag_r   [ENTRIES];
  logic [CNT_W-1:0] cnt_r   [ENTRIES];
  logic [31:0]      tgt_r   [ENTRIES];
  logic [STAT_W-1:0] nbr_r;
  logic [STAT_W-1:0] nmiss_r;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic             lk_taken_s;
  logic [31:0]      lk_tpc_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic             upd_fire_s;
  logic             mispred_s;
  logic [CNT_W-1:0] upd_cnt_nxt_s;
  logic             unused_s;

  assign lk_idx_s  = w_if_pc[IDX_W+1:2];
  assign lk_tag_s  = w_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx_s = w_upd_pc[IDX_W+1:2];
  assign upd_tag_s = w_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_fire_s = w_ce & w_upd_valid & w_upd_is_br;
  assign unused_s   = ^{w_if_pc, w_upd_pc};

  // Fetch-side lookup: pre-update table contents, no bypass from the Ex write port.
  always_comb begin
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    lk_taken_s = lk_hit_s && cnt_r[lk_idx_s][CNT_W-1];
    if (lk_taken_s) begin
      lk_tpc_s = tgt_r[lk_idx_s];
    end else begin
      lk_tpc_s = 32'd0;
    end
  end

  // Ex-side hit detection, redirect flag and saturating next counter value.
  always_comb begin
    upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    mispred_s     = w_upd_valid & w_upd_is_br &
                    ((w_upd_pred_taken != w_upd_taken) |
                     (w_upd_taken & (w_upd_pred_tpc != w_upd_tpc)));
    upd_cnt_nxt_s = cnt_r[upd_idx_s];
    if (w_upd_taken) begin
      if (cnt_r[upd_idx_s] != CNT_MAX) begin
        upd_cnt_nxt_s = cnt_r[upd_idx_s] + CNT_W'(1);
      end else begin
        upd_cnt_nxt_s = CNT_MAX;
      end
    end else begin
      if (cnt_r[upd_idx_s] != CNT_ZERO) begin
        upd_cnt_nxt_s = cnt_r[upd_idx_s] - CNT_W'(1);
      end else begin
        upd_cnt_nxt_s = CNT_ZERO;
      end
    end
  end

  // BTB table: train on hits, allocate only on taken misses.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= {TAG_W{1'b0}};
        cnt_r[i]   <= CNT_WNT;
        tgt_r[i]   <= 32'd0;
      end
    end else if (upd_fire_s) begin
      if (upd_hit_s) begin
        cnt_r[upd_idx_s] <= upd_cnt_nxt_s;
        if (w_upd_taken) begin
          tgt_r[upd_idx_s] <= w_upd_tpc;
        end
      end else if (w_upd_taken) begin
        valid_r[upd_idx_s] <= 1'b1;
        tag_r[upd_idx_s]   <= upd_tag_s;
        cnt_r[upd_idx_s]   <= CNT_WT;
        tgt_r[upd_idx_s]   <= w_upd_tpc;
      end
    end
  end

  // Saturating branch and mispredict statistics for the debug path.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      nbr_r   <= {STAT_W{1'b0}};
      nmiss_r <= {STAT_W{1'b0}};
    end else if (upd_fire_s) begin
      if (nbr_r != STAT_MAX) begin
        nbr_r <= nbr_r + STAT_W'(1);
      end
      if (mispred_s && (nmiss_r != STAT_MAX)) begin
        nmiss_r <= nmiss_r + STAT_W'(1);
      end
    end
  end

  assign w_pred_taken  = lk_taken_s;
  assign w_pred_tpc    = lk_tpc_s;
  assign w_upd_mispred = mispred_s;
  assign w_nbr         = nbr_r;
  assign w_nmiss       = nmiss_r;

endmodule

// File: tb/tb_m_bpred.sv
// Directed bench for m_bpred (64 entries, 8-bit tags, 2-bit counters, 4-bit statistics)
// with a table-level reference model checked every cycle plus hand-computed expectations.
module tb_m_bpred;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_tpc;
  logic        upd_valid = 1'b0;
  logic        upd_is_br = 1'b0;
  logic [31:0] upd_pc = 32'd0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_tpc = 32'd0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_tpc = 32'd0;
  logic        upd_mispred;
  logic [3:0]  nbr;
  logic [3:0]  nmiss;

  int checks = 0;
  int failures = 0;

  m_bpred #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .STAT_W(4)) dut (
    .w_clk(clk), .w_rst_n(rst_n), .w_ce(ce), .w_if_pc(if_pc),
    .w_pred_taken(pred_taken), .w_pred_tpc(pred_tpc),
    .w_upd_valid(upd_valid), .w_upd_is_br(upd_is_br), .w_upd_pc(upd_pc),
    .w_upd_taken(upd_taken), .w_upd_tpc(upd_tpc),
    .w_upd_pred_taken(upd_pred_taken), .w_upd_pred_tpc(upd_pred_tpc),
    .w_upd_mispred(upd_mispred), .w_nbr(nbr), .w_nmiss(nmiss)
  );

  always #5 clk = ~clk;

  // Reference model: one record per BTB slot, counter as a plain integer 0..3.
  bit          m_valid [64];
  int          m_tag   [64];
  int          m_cnt   [64];
  logic [31:0] m_tgt   [64];
  int          m_nbr;
  int          m_nmiss;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic int tg(input logic [31:0] pc);
    return int'((pc / 32'd256) % 32'd256);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[ix(pc)] && (m_tag[ix(pc)] == tg(pc));
  endfunction

  function automatic logic [31:0] exp_taken(input logic [31:0] pc);
    return (m_hit(pc) && (m_cnt[ix(pc)] >= 2)) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_tpc(input logic [31:0] pc);
    return (exp_taken(pc) == 32'd1) ? m_tgt[ix(pc)] : 32'd0;
  endfunction

  function automatic logic [31:0] exp_mis();
    bit wrong;
    wrong = (upd_pred_taken != upd_taken) || (upd_taken && (upd_pred_tpc != upd_tpc));
    return (upd_valid && upd_is_br && wrong) ? 32'd1 : 32'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] <= 1'b0;
        m_tag[i]   <= 0;
        m_cnt[i]   <= 1;
        m_tgt[i]   <= 32'd0;
      end
      m_nbr   <= 0;
      m_nmiss <= 0;
    end else if (ce && upd_valid && upd_is_br) begin
      m_nbr <= (m_nbr < 15) ? m_nbr + 1 : 15;
      if (exp_mis() == 32'd1) m_nmiss <= (m_nmiss < 15) ? m_nmiss + 1 : 15;
      if (m_hit(upd_pc)) begin
        m_cnt[ix(upd_pc)] <= upd_taken ? ((m_cnt[ix(upd_pc)] < 3) ? m_cnt[ix(upd_pc)] + 1 : 3)
                                       : ((m_cnt[ix(upd_pc)] > 0) ? m_cnt[ix(upd_pc)] - 1 : 0);
        if (upd_taken) m_tgt[ix(upd_pc)] <= upd_tpc;
      end else if (upd_taken) begin
        m_valid[ix(upd_pc)] <= 1'b1;
        m_tag[ix(upd_pc)]   <= tg(upd_pc);
        m_cnt[ix(upd_pc)]   <= 2;
        m_tgt[ix(upd_pc)]   <= upd_tpc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_pred_taken", 32'(pred_taken), exp_taken(if_pc));
      chk("model_pred_tpc", pred_tpc, exp_tpc(if_pc));
      chk("model_mispred", 32'(upd_mispred), exp_mis());
      chk("model_nbr", 32'(nbr), 32'(m_nbr));
      chk("model_nmiss", 32'(nmiss), 32'(m_nmiss));
    end
  end

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tpc,
                     input logic pt, input logic [31:0] ptpc, input logic want_mis);
    upd_valid = 1'b1; upd_is_br = 1'b1; upd_pc = pc; upd_taken = t;
    upd_tpc = tpc; upd_pred_taken = pt; upd_pred_tpc = ptpc;
    #1 chk("lit_mispred", 32'(upd_mispred), 32'(want_mis));
    @(posedge clk);
    #1 upd_valid = 1'b0; upd_is_br = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; if_pc = 32'h100;
    #1 chk("reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("reset_pred_tpc", pred_tpc, 32'd0);
    chk("reset_nbr", 32'(nbr), 32'd0);

    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    #1 chk("alloc_nmiss", 32'(nmiss), 32'd1);
    chk("alloc_taken", 32'(pred_taken), 32'd1);
    chk("alloc_tpc", pred_tpc, 32'h80);

    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    #1 chk("hyst_nt_once", 32'(pred_taken), 32'd0);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
    #1 chk("hyst_still_taken", 32'(pred_taken), 32'd1);
    chk("hyst_nbr", 32'(nbr), 32'd5);
    chk("hyst_nmiss", 32'(nmiss), 32'd4);

    upd(32'h200, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    if_pc = 32'h100;
    #1 chk("alias_old_miss", 32'(pred_taken), 32'd0);
    if_pc = 32'h200;
    #1 chk("alias_new_taken", 32'(pred_taken), 32'd1);
    chk("alias_new_tpc", pred_tpc, 32'h200);

    // Same-cycle lookup and update of one index returns the old contents.
    @(posedge clk); #1;
    upd_valid = 1'b1; upd_is_br = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1;
    upd_tpc = 32'h300; upd_pred_taken = 1'b1; upd_pred_tpc = 32'h200;
    #1 chk("same_old_tpc", pred_tpc, 32'h200);
    chk("same_tgt_mispred", 32'(upd_mispred), 32'd1);
    @(posedge clk); #1 upd_valid = 1'b0; upd_is_br = 1'b0;
    chk("same_new_tpc", pred_tpc, 32'h300);

    if_pc = 32'h140;
    upd_valid = 1'b1; upd_is_br = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1;
    upd_tpc = 32'h40; upd_pred_taken = 1'b0; upd_pred_tpc = 32'h0;
    #1 chk("same_alloc_before", 32'(pred_taken), 32'd0);
    @(posedge clk); #1 upd_valid = 1'b0; upd_is_br = 1'b0;
    chk("same_alloc_after", 32'(pred_taken), 32'd1);
    chk("same_nbr", 32'(nbr), 32'd8);

    ce = 1'b0;
    upd(32'h300, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1);
    if_pc = 32'h300;
    #1 chk("ce_no_alloc", 32'(pred_taken), 32'd0);
    chk("ce_nbr_hold", 32'(nbr), 32'd8);
    chk("ce_nmiss_hold", 32'(nmiss), 32'd7);
    ce = 1'b1;

    upd_valid = 1'b1; upd_is_br = 1'b0; upd_pc = 32'h300;
    upd_taken = 1'b0; upd_pred_taken = 1'b1;
    #1 chk("nonbr_mispred", 32'(upd_mispred), 32'd0);
    @(posedge clk); #1 upd_valid = 1'b0;
    chk("nonbr_nbr", 32'(nbr), 32'd8);

    upd(32'h140, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    upd(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    upd(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    upd(32'h140, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1);
    if_pc = 32'h140;
    #1 chk("floor_not_taken", 32'(pred_taken), 32'd0);
    chk("floor_nbr", 32'(nbr), 32'd12);
    chk("floor_nmiss", 32'(nmiss), 32'd9);
    upd(32'h140, 1'b1, 32'h48, 1'b0, 32'h0, 1'b1);
    #1 chk("floor_retaken_tpc", pred_tpc, 32'h48);

    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("rst_nbr", 32'(nbr), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      upd(32'h400 + 32'(i * 4), 1'b1, 32'h800, 1'b0, 32'h0, 1'b1);
    end
    if_pc = 32'h400;
    #1 chk("sat_nbr", 32'(nbr), 32'd15);
    chk("sat_nmiss", 32'(nmiss), 32'd15);
    chk("sat_lookup_tpc", pred_tpc, 32'h800);

    upd_valid = 1'b1; upd_is_br = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1;
    upd_tpc = 32'h900; upd_pred_taken = 1'b0; upd_pred_tpc = 32'h0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("midrst_nbr", 32'(nbr), 32'd0);
    chk("midrst_nmiss", 32'(nmiss), 32'd0);
    chk("midrst_taken", 32'(pred_taken), 32'd0);
    chk("midrst_tpc", pred_tpc, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 upd_valid = 1'b0; upd_is_br = 1'b0;
    chk("release_first_nbr", 32'(nbr), 32'd1);
    chk("release_first_nmiss", 32'(nmiss), 32'd1);

    repeat (3) @(posedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_bpred.md
# m_bpred

Parametrised branch predictor for the 5-stage RV32 pipeline processor: a direct-mapped branch target buffer with saturating per-entry direction counters. It replaces the fixed predict-not-taken/flush scheme. IF looks it up each cycle to choose the next PC. Ex writes resolved branches back and gets a mispredict flag to drive the flush. It also keeps branch and mispredict statistic counters for the w_led/VIO debug path.

## Interface
- ENTRIES, 64: number of BTB entries; power of two, 2..1024; IDX_W = log2(ENTRIES).
- TAG_W, 8: tag width; 0 < TAG_W, IDX_W+TAG_W+2 <= 32.
- CNT_W, 2: direction counter width, 1..4.
- STAT_W, 32: width of statistic counters.

- w_clk  in  1  processor clock; all state updates on posedge.
- w_rst_n  in  1  asynchronous, active-low reset.
- w_ce  in  1  clock enable; 0 freezes all state.
- w_if_pc  in  32  PC being fetched (word aligned).
- w_pred_taken  out  1  predict taken for w_if_pc (combinational).
- w_pred_tpc  out  32  predicted target; 0 when w_pred_taken=0.
- w_upd_valid  in  1  Ex stage holds a real instruction.
- w_upd_is_br  in  1  that instruction is BEQ/BNE.
- w_upd_pc  in  32  PC of the Ex instruction.
- w_upd_taken  in  1  resolved direction.
- w_upd_tpc  in  32  resolved target (pc+imm).
- w_upd_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- w_upd_pred_tpc  in  32  predicted target, carried down the pipe.
- w_upd_mispred  out  1  redirect required (combinational).
- w_nbr  out  STAT_W  resolved branch count.
- w_nmiss  out  STAT_W  mispredict count.

## Operation
- Entry: valid bit, TAG_W tag, CNT_W counter, 32-bit target.
- idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; the same slicing is used for lookup and update.
- Lookup hit = valid[idx] & tag match. w_pred_taken = hit & counter MSB. w_pred_tpc = target when taken, else 0.
- Update fires when w_ce & w_upd_valid & w_upd_is_br at posedge.
- On a hit, the counter saturates up if taken, down if not taken. The target is overwritten with w_upd_tpc only when taken.
- On a miss with taken=1, the entry is allocated or replaced: valid=1, new tag, counter = 2^(CNT_W-1) (weakly taken), target = w_upd_tpc.
- On a miss with taken=0, nothing changes; no allocation.
- w_upd_mispred = w_upd_valid & w_upd_is_br & ((w_upd_pred_taken != w_upd_taken) | (w_upd_taken & w_upd_pred_tpc != w_upd_tpc)).
- When w_upd_valid & !w_upd_is_br, w_upd_mispred = 0 and there is no update. Non-branch instructions never predicted taken via the BTB, since only taken branches allocate. A non-branch that aliases a stale entry is outside this block's scope; Ex treats it as a normal instruction.
- Statistics: on each update event, w_nbr increments; w_nmiss also increments if w_upd_mispred. Both saturate at all-ones; no wrap.
- CNT_W=1: the counter is a last-outcome bit; allocate sets it to 1.

## Timing
- Lookup is zero-latency combinational from w_if_pc; IF uses it in the same cycle.
- Updates become visible to lookup on the cycle after the posedge.
- Same-cycle lookup and update of one idx: the lookup returns the pre-update contents. No bypass.
- Async reset assertion, at any time including mid-update: immediately valid=0 for all entries, counters = 2^(CNT_W-1)-1 (weakly not-taken), tags/targets = 0, w_nbr = w_nmiss = 0. Hence w_pred_taken=0 and w_pred_tpc=0 immediately.
- Reset release is registered-clean; the first update is accepted on the first posedge with w_rst_n=1.
- w_ce=0: lookup outputs remain valid, w_upd_mispred is still computed, no state changes, statistics hold.
- Counter arithmetic is CNT_W unsigned, clamped at 0 and 2^CNT_W-1.

## Test plan
- Reset then lookup: pulse w_rst_n=0 for 2 cycles, then w_if_pc=0x100. Expect w_pred_taken=0, w_pred_tpc=0, w_nbr=0.
- Allocate: update pc=0x100, taken=1, tpc=0x80, pred_taken=0. Expect w_upd_mispred=1, w_nmiss=1. The next cycle, lookup 0x100 gives taken=1, tpc=0x80.
- Hysteresis, CNT_W=2: after the allocation above, update pc=0x100 not-taken once. Lookup now predicts not taken (counter 01). Then two taken updates; the counter reaches 11. One not-taken update leaves the prediction taken.
- Aliasing, ENTRIES=64: allocate 0x100 taken, then allocate 0x100+(64<<2)*... with the same idx and a different tag, taken to 0x200. Lookup 0x100 misses; lookup of the new PC gives tpc=0x200.
- Same-cycle lookup/update plus w_ce gating:
  - Updating idx X while looking up X returns the old value; the new value appears next cycle.
  - With w_ce=0 the update is ignored and the statistics are unchanged.
- Saturation, STAT_W=4: issue 20 mispredicting updates. Expect w_nbr=w_nmiss=15. Async reset mid-sequence clears both the same cycle.
